uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART datapath, the receive-direction counterpart of the TX FIFO path. It samples the asynchronous `rx` line with 16x oversampling, checks the start bit and the stop bit, and deserialises 8N1 frames (LSB first). Each good byte is presented as `rx_data` with a one-cycle `rx_valid` strobe. A frame whose stop bit is bad produces an `rx_frame_err` strobe instead.

## Interface
- `BAUD_DIV`, default 27: clk cycles per oversample tick; bit period = 16*`BAUD_DIV` clk. Legal range ≥ 2.
- `clk` input 1: single clock domain; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line; idles high.
- `rx_data` output 8: last correctly received byte; holds until the next good frame.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is new in the same cycle.
- `rx_frame_err` output 1: one-cycle pulse; the stop bit was sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation
- **Input synchroniser**
  - Two-flop synchroniser; both flops reset to 1.
  - The FSM only ever sees the synchronised `rx_s`.
- **Baud counter**
  - Width `$clog2(BAUD_DIV)`; counts 0..`BAUD_DIV`-1 and wraps.
  - `tick` = (count == `BAUD_DIV`-1).
  - Held at 0 in IDLE and WAIT_HIGH.
- **Sample counter:** 4 bits, counts ticks. **Bit counter:** 3 bits. **Shift register:** 8 bits, shifts right, new bit enters [7].
- **IDLE**
  - `rx_s`==0: go to START; clear baud, sample and bit counters.
- **START**
  - On tick 8 (mid start bit), sample `rx_s`.
  - 1: false start, go to IDLE, no strobe.
  - 0: go to DATA; clear the sample counter.
- **DATA**
  - Every 16th tick (bit centre), shift in `rx_s`.
  - After the 8th bit, go to STOP.
- **STOP**
  - On the 16th tick, sample `rx_s`.
  - 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rx_s`==1 (break/line-low protection), then go to IDLE.
- **Boundary conditions**
  - `rx_valid` and `rx_frame_err` are never high together.
  - Each strobe is high for exactly 1 cycle.
  - Back-to-back frames with zero idle: IDLE is entered at mid stop bit, so the next start edge (half a bit later) is caught.
  - A low glitch shorter than 8 ticks is rejected in START.
- **Reset**
  - `rst` at any time, including mid-frame: state=IDLE, all counters 0, shift register 0.
  - Outputs: `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0; synchroniser flops = 1.
  - A partially received frame is discarded.

## Timing
- **Edge reference:** E0 = clk edge at which the first synchroniser flop captures `rx`=0.
- **Sync latency:** `rx_s` is low after E0+1. The FSM enters START at E0+2, and `rx_busy` rises after that edge.
- **Tick timing:** the n-th tick is acted on at edge E0+2+n*`BAUD_DIV`.
- **Sample points:**
  - Start bit: tick 8.
  - Data bit i (i=0..7): tick 8+16*(i+1).
  - Stop bit: tick 152.
- **Strobes:** `rx_valid` or `rx_frame_err` goes high for the cycle after edge E0+2+152*`BAUD_DIV`, and `rx_busy` falls at that same edge.
- **Example:** `BAUD_DIV`=4 gives a strobe 610 cycles after E0.
- **Tolerance:** accepts baud mismatch up to ±3%, since sampling is at bit centre.

## Test plan
All scenarios use `BAUD_DIV`=4, so one bit = 64 clk.
- **Single byte:** drive 0xA5 (8N1, LSB first) → `rx_data`=0xA5 and `rx_valid` high for exactly 1 cycle, 610 clk after E0; `rx_frame_err` stays 0.
- **Glitch rejection:** `rx` low for 20 clk, then high → `rx_busy` pulses, and there is no `rx_valid` or `rx_frame_err`; state returns to IDLE.
- **Framing error:** send 0x5A with the stop bit driven 0, hold `rx` low for 200 clk more, then release, then send 0x3C.
  - `rx_frame_err` pulses once and `rx_data` stays at its prior value.
  - No start is detected while the line is held low.
  - 0x3C is then received with `rx_valid`.
- **Back-to-back:** 0x00, 0xFF, 0x81 with no idle gap → three `rx_valid` pulses spaced exactly 640 clk apart, with data 0x00, 0xFF, 0x81.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of 0xC3.
  - All outputs read reset values the cycle after.
  - No strobe occurs for the truncated frame.
  - A following full frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
// The rx line is synchronised, the start bit is checked at its centre,
// eight data bits are shifted in LSB first at their centres and the stop
// bit is checked. A good frame updates rx_data with a one-cycle rx_valid;
// a low stop bit gives a one-cycle rx_frame_err and waits for the line to
// return high before a new start can be detected.
module uart_rx #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  // Baud counter width; guarded so a degenerate divider still gets 1 bit.
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);

  // Sample counter values: tick 8 is mid start bit, every 16th tick after
  // that is the centre of the next bit.
  localparam logic [3:0] SAMP_MID  = 4'd7;
  localparam logic [3:0] SAMP_LAST = 4'd15;
  localparam logic [2:0] BIT_LAST  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Synchroniser
  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;

  // FSM and datapath
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_d;
  logic [3:0]       sample_q;
  logic [3:0]       sample_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             tick_s;

  // Registered outputs
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             ferr_q;
  logic             ferr_d;
  logic             busy_q;
  logic             busy_d;

  assign rx_s   = sync2_q;
  assign tick_s = (baud_q == BAUD_MAX);

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and datapath logic for the receive FSM.
  always_comb begin
    state_d  = state_q;
    baud_d   = tick_s ? BAUD_ZERO : (baud_q + BAUD_ONE);
    sample_d = tick_s ? (sample_q + 4'd1) : sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Counters are parked so the start-bit timing begins from zero.
        baud_d   = BAUD_ZERO;
        sample_d = 4'd0;
        if (!rx_s) begin
          state_d = ST_START;
          bit_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_s && (sample_q == SAMP_MID)) begin
          if (rx_s) begin
            // Line went back high before mid start bit: a glitch.
            state_d = ST_IDLE;
          end else begin
            // Re-align the sample counter to the start-bit centre.
            state_d  = ST_DATA;
            sample_d = 4'd0;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_s && (sample_q == SAMP_LAST)) begin
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit to catch a
        // back-to-back start edge.
        if (tick_s && (sample_q == SAMP_LAST)) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for new starts.
        baud_d   = BAUD_ZERO;
        sample_d = 4'd0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        baud_d   = BAUD_ZERO;
        sample_d = 4'd0;
        bit_d    = 3'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= BAUD_ZERO;
      sample_q <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  // Output registers: held data, single-cycle strobes and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with BAUD_DIV=4 (one bit = 64 clk).
// The driver serialises frames and pushes the expected strobe (kind, data,
// cycle) computed from frame arithmetic; a monitor pops on every strobe.
module tb_uart_rx;

  localparam int BD  = 4;
  localparam int BIT = 16 * BD;
  localparam int LAT = 2 + 152 * BD;   // E0 to strobe edge

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data;
  bit         mon_en = 1'b0;

  // Count rising edges so strobe times can be compared to E0 + LAT.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one 8N1 frame starting now (called on a falling edge).
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    rx     = 1'b0;
    e.when = cyc + 1 + LAT;
    if (stop_ok) begin
      model_data = b;
      e.is_err   = 1'b0;
      e.data     = b;
    end else begin
      e.is_err = 1'b1;
      e.data   = model_data;
    end
    sbq.push_back(e);
    wait_n(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_n(BIT);
    end
    rx = stop_ok;
    wait_n(BIT);
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst && (rx_valid || rx_frame_err)) begin
      check("strobe_exclusive", int'(rx_valid & rx_frame_err), 0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected none at cycle %0d",
                 rx_valid, rx_frame_err, cyc);
      end else begin
        e = sbq.pop_front();
        check("strobe_kind_err", int'(rx_frame_err), int'(e.is_err));
        check("strobe_data", int'(rx_data), int'(e.data));
        check("strobe_time", cyc, e.when);
      end
    end
  end

  initial begin
    logic [7:0] c3;
    int         waited;
    rst        = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;
    wait_n(3);
    check("reset_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_ferr", int'(rx_frame_err), 0);
    check("reset_busy", int'(rx_busy), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_n(10);

    // Single byte
    send_frame(8'hA5, 1'b1);
    wait_n(20);
    check("single_hold", int'(rx_data), 8'hA5);

    // Glitch rejection: 20 clk low pulse
    rx = 1'b0;
    wait_n(5);
    check("glitch_busy_high", int'(rx_busy), 1);
    wait_n(15);
    rx = 1'b1;
    wait_n(60);
    check("glitch_busy_low", int'(rx_busy), 0);

    // Framing error, line held low, then a good frame
    send_frame(8'h5A, 1'b0);
    wait_n(200);
    check("break_busy_high", int'(rx_busy), 1);
    check("break_hold_data", int'(rx_data), 8'hA5);
    rx = 1'b1;
    wait_n(10);
    check("break_busy_low", int'(rx_busy), 0);
    send_frame(8'h3C, 1'b1);
    wait_n(10);

    // Back-to-back frames, no idle
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    wait_n(20);

    // Reset during data bit 3 of 0xC3
    c3 = 8'hC3;
    rx = 1'b0;
    wait_n(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = c3[i];
      wait_n(BIT);
    end
    rx = c3[3];
    wait_n(32);
    mon_en = 1'b0;
    rst    = 1'b1;
    rx     = 1'b1;
    wait_n(1);
    rst        = 1'b0;
    model_data = 8'h00;
    check("midrst_data", int'(rx_data), 0);
    check("midrst_valid", int'(rx_valid), 0);
    check("midrst_ferr", int'(rx_frame_err), 0);
    check("midrst_busy", int'(rx_busy), 0);
    mon_en = 1'b1;
    wait_n(700);
    check("midrst_no_strobe_pending", sbq.size(), 0);
    send_frame(8'h96, 1'b1);
    wait_n(20);

    // Randomised traffic
    for (int n = 0; n < 24; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 6) begin
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        rx = 1'b1;
        wait_n(int'($urandom_range(0, 40)));
      end else if (op == 7) begin
        rx = 1'b0;
        wait_n(int'($urandom_range(1, 28)));
        rx = 1'b1;
        wait_n(80);
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b0);
        wait_n(int'($urandom_range(0, 150)));
        rx = 1'b1;
        wait_n(8);
      end
    end

    // Drain: bounded wait for outstanding expectations
    rx     = 1'b1;
    waited = 0;
    while ((sbq.size() != 0) && (waited < 2000)) begin
      wait_n(1);
      waited++;
    end
    check("scoreboard_drained", sbq.size(), 0);
    check("final_idle", int'(rx_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
